// File: rtl/servo_setpoint_ramp.sv
// Servo setpoint ramp: turns angle commands into a pulse-width target and
// slews the pulse width toward it by at most STEP ticks per PWM frame.
module servo_setpoint_ramp #(
  parameter int unsigned MIN_WIDTH     = 6000,
  parameter int unsigned MAX_WIDTH     = 28800,
  parameter int unsigned TICKS_PER_DEG = 127,
  parameter int unsigned MAX_ANGLE     = 180,
  parameter int unsigned STEP          = 500,
  parameter int unsigned INIT_WIDTH    = 17430
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_angle,
  output logic        cmd_ready,
  input  logic        frame_tick,
  output logic [31:0] pulse_width,
  output logic        at_target,
  output logic        cmd_err
);

  localparam logic [7:0]         LP_MAX_ANGLE  = 8'(MAX_ANGLE);
  localparam logic [15:0]        LP_TICKS      = 16'(TICKS_PER_DEG);
  localparam logic [31:0]        LP_MIN_WIDTH  = 32'(MIN_WIDTH);
  localparam logic [31:0]        LP_MAX_WIDTH  = 32'(MAX_WIDTH);
  localparam logic [31:0]        LP_INIT_WIDTH = 32'(INIT_WIDTH);
  localparam logic [31:0]        LP_STEP_U     = 32'(STEP);
  localparam logic signed [32:0] LP_STEP       = $signed({1'b0, LP_STEP_U});

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic [7:0]         w_angle_clamped;
  logic               w_angle_over;
  logic [7:0]         r_angle;
  logic [15:0]        r_product;
  logic [31:0]        w_sum;
  logic [31:0]        w_target_new;
  logic [31:0]        r_target;
  logic [31:0]        r_pulse_width;
  logic signed [32:0] w_diff;
  logic [31:0]        w_pulse_next;
  logic               r_at_target;
  logic               r_cmd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_next = S_CONV;
        end
      end
      S_CONV:  w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept        = cmd_valid && (r_state == S_IDLE);
  assign w_angle_over    = (cmd_angle > LP_MAX_ANGLE);
  assign w_angle_clamped = w_angle_over ? LP_MAX_ANGLE : cmd_angle;

  assign w_sum        = LP_MIN_WIDTH + {16'd0, r_product};
  assign w_target_new = (w_sum > LP_MAX_WIDTH) ? LP_MAX_WIDTH : w_sum;

  // Slew always sees the registered target, so a LOAD landing on the same
  // edge as frame_tick only affects the following frame.
  assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_pulse_width});

  always_comb begin
    w_pulse_next = r_target;
    if (w_diff > LP_STEP) begin
      w_pulse_next = r_pulse_width + LP_STEP_U;
    end else if (w_diff < -LP_STEP) begin
      w_pulse_next = r_pulse_width - LP_STEP_U;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_angle       <= 8'd0;
      r_product     <= 16'd0;
      r_target      <= LP_INIT_WIDTH;
      r_pulse_width <= LP_INIT_WIDTH;
      r_at_target   <= 1'b1;
      r_cmd_err     <= 1'b0;
    end else begin
      r_cmd_err   <= w_accept && w_angle_over;
      r_at_target <= (r_pulse_width == r_target);
      if (w_accept) begin
        r_angle <= w_angle_clamped;
      end
      if (r_state == S_CONV) begin
        r_product <= 16'(r_angle) * LP_TICKS;
      end
      if (r_state == S_LOAD) begin
        r_target <= w_target_new;
      end
      if (frame_tick) begin
        r_pulse_width <= w_pulse_next;
      end
    end
  end

  assign pulse_width = r_pulse_width;
  assign at_target   = r_at_target;
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_servo_setpoint_ramp.sv
// Directed bench for servo_setpoint_ramp: handshake timing, clamping,
// per-frame slew, simultaneous LOAD/tick and asynchronous reset.
module tb_servo_setpoint_ramp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_angle;
  logic        cmd_ready;
  logic        frame_tick;
  logic [31:0] pulse_width;
  logic        at_target;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_setpoint_ramp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_angle  (cmd_angle),
    .cmd_ready  (cmd_ready),
    .frame_tick (frame_tick),
    .pulse_width(pulse_width),
    .at_target  (at_target),
    .cmd_err    (cmd_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle frame strobe; returns at the negedge after the tick edge.
  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Presents a command, waits (bounded) for acceptance and returns at the
  // negedge of the cycle following the accept edge.
  task automatic send_cmd(input logic [7:0] ang);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = ang;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_pw;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_angle  = 8'd0;
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pw", pulse_width, 32'd17430);
    check_val("rst_at", {31'd0, at_target}, 32'd1);
    check_val("rst_rdy", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) frame();
    check_val("idle_pw", pulse_width, 32'd17430);

    // Angle 0: ready timing, then slew down by 500 per frame to 6000.
    send_cmd(8'd0);
    check_val("a0_rdy_n1", {31'd0, cmd_ready}, 32'd0);
    check_val("a0_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    check_val("a0_rdy_n2", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_val("a0_rdy_n3", {31'd0, cmd_ready}, 32'd1);
    for (int k = 1; k <= 23; k++) begin
      repeat (99) @(negedge clk);
      frame();
      exp_pw = (k < 23) ? 32'(17430 - 500 * k) : 32'd6000;
      check_val($sformatf("a0_pw_%0d", k), pulse_width, exp_pw);
    end
    check_val("a0_at_lag", {31'd0, at_target}, 32'd0);
    @(negedge clk);
    check_val("a0_at", {31'd0, at_target}, 32'd1);

    // Angle 200: error pulse and MAX_WIDTH clamp (28800, not 28860).
    send_cmd(8'd200);
    check_val("clamp_err_hi", {31'd0, cmd_err}, 32'd1);
    @(negedge clk);
    check_val("clamp_err_lo", {31'd0, cmd_err}, 32'd0);
    for (int k = 1; k <= 46; k++) begin
      frame();
      if (k == 45) check_val("clamp_pw45", pulse_width, 32'd28500);
      if (k == 46) check_val("clamp_pw46", pulse_width, 32'd28800);
    end

    // Back-to-back commands with cmd_valid held: 45 then 90.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = 8'd45;
    check_val("hs_rdy0", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_angle = 8'd90;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("hs_gap", 32'(n + 1), 32'd3);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("hs_rdy_low", {31'd0, cmd_ready}, 32'd0);
    for (int k = 1; k <= 23; k++) begin
      frame();
      if (k == 22) check_val("hs_pw22", pulse_width, 32'd17800);
      if (k == 23) check_val("hs_pw23", pulse_width, 32'd17430);
    end
    @(negedge clk);
    check_val("hs_at", {31'd0, at_target}, 32'd1);

    // LOAD coincides with frame_tick: old target (17430) used first.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = 8'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_val("sim_old_pw", pulse_width, 32'd17430);
    check_val("sim_rdy", {31'd0, cmd_ready}, 32'd1);
    frame();
    check_val("sim_new_pw", pulse_width, 32'd16930);

    // Back-to-back ticks are both honoured.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    check_val("b2b_pw1", pulse_width, 32'd16430);
    @(negedge clk);
    frame_tick = 1'b0;
    check_val("b2b_pw2", pulse_width, 32'd15930);

    // Back to 90 deg (last step has diff exactly STEP), then angle 91.
    send_cmd(8'd90);
    @(negedge clk);
    repeat (3) frame();
    check_val("ret90_pw", pulse_width, 32'd17430);
    send_cmd(8'd91);
    @(negedge clk);
    frame();
    check_val("small_pw", pulse_width, 32'd17557);
    check_val("small_err", {31'd0, cmd_err}, 32'd0);

    // Asynchronous reset while a command sits in CONV.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = 8'd0;
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_val("arst_pw", pulse_width, 32'd17430);
    check_val("arst_rdy", {31'd0, cmd_ready}, 32'd1);
    check_val("arst_at", {31'd0, at_target}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frame();
    check_val("arst_hold_pw", pulse_width, 32'd17430);
    check_val("arst_hold_at", {31'd0, at_target}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_setpoint_ramp.md
# servo_setpoint_ramp

Upstream stage for the servo PWM generator. It accepts angle commands over a valid/ready handshake and converts each to a pulse width in 12 MHz clock ticks. Once per PWM frame it slews its output `pulse_width` toward that target by a bounded step, so the servo never jumps. Its `pulse_width` output feeds the PWM generator's width input directly, and the generator's frame-start strobe drives `frame_tick`.

## Interface
- `MIN_WIDTH`, default 6000: pulse width for 0 deg, in ticks (0.5 ms at 12 MHz).
- `MAX_WIDTH`, default 28800: upper clamp for pulse width, in ticks (2.4 ms).
- `TICKS_PER_DEG`, default 127: width increment per degree.
- `MAX_ANGLE`, default 180: largest legal angle. Larger commands are clamped to it.
- `STEP`, default 500: largest change of `pulse_width` per frame, in ticks.
- `INIT_WIDTH`, default 17430: reset value of target and output (90 deg).
- `clk` input, 1 bit: system clock, 12 MHz.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid` input, 1 bit: an angle command is presented.
- `cmd_angle` input, 8 bits: commanded angle in degrees, unsigned.
- `cmd_ready` output, 1 bit: the block can accept a command this cycle.
- `frame_tick` input, 1 bit: single-cycle strobe at the start of each 20 ms PWM frame.
- `pulse_width` output, 32 bits: current pulse width in ticks, to the PWM stage.
- `at_target` output, 1 bit: high when `pulse_width` equals the target.
- `cmd_err` output, 1 bit: one-cycle pulse when an accepted angle exceeded `MAX_ANGLE`.

## Operation
- Reset values, applied asynchronously while `rst_n` is low:
  - `target` = `pulse_width` = `INIT_WIDTH`.
  - `cmd_ready` = 1, `at_target` = 1, `cmd_err` = 0.
  - FSM state = IDLE.
- Command FSM, three states:
  - IDLE: `cmd_ready` = 1. When `cmd_valid` is high, the command is accepted. The block latches `cmd_angle`, clamped to `MAX_ANGLE`, and pulses `cmd_err` on the next cycle if clamping occurred. Next state is CONV.
  - CONV: `cmd_ready` = 0. Register `product` = angle × `TICKS_PER_DEG`, unsigned, 16 bits. Next state is LOAD.
  - LOAD: `cmd_ready` = 0.
    - `target` ← min(`MIN_WIDTH` + `product`, `MAX_WIDTH`), computed in 32 bits.
    - Next state is IDLE.
- Commands presented while `cmd_ready` = 0 are not accepted. The sender must hold `cmd_valid` until the handshake completes.
- Slew rule: on each cycle where `frame_tick` = 1, with diff = `target` − `pulse_width` as a signed 33-bit value:
  - If |diff| ≤ `STEP`: `pulse_width` ← `target`.
  - Otherwise: `pulse_width` ← `pulse_width` ± `STEP`, moving toward `target`.
- `pulse_width` changes only on `frame_tick`. This keeps the width stable for the whole frame.
- `at_target` = (`pulse_width` == `target`), registered.
- Simultaneous events:
  - `frame_tick` in the same cycle as a LOAD: the slew uses the old `target`, and the new target takes effect from the next tick.
  - Back-to-back `frame_tick` pulses are each honoured.
- Reset mid-operation (any FSM state or mid-slew): everything returns to reset values immediately. Any partially accepted command is discarded.

## Timing
- Handshake: accept on edge N (`cmd_valid` & `cmd_ready`). Then:
  - `cmd_ready` is low in cycles N+1 and N+2.
  - `target` is updated at edge N+2.
  - `cmd_ready` is high again at N+3.
- Maximum command throughput is one command per 3 cycles.
- `cmd_err` is high for exactly the one cycle after acceptance.
- Output latency: `pulse_width` moves at the first `frame_tick` edge after `target` is updated. `at_target` reflects the change one cycle after that.
- Slew time: a full 0→180 deg swing (22860 ticks) takes ceil(22860/500) = 46 frames, about 0.92 s.

## Test plan
- Reset: assert `rst_n` = 0 mid-run, then release. Required response:
  - `pulse_width` = 17430, `at_target` = 1, `cmd_ready` = 1.
  - No change to `pulse_width` until a command is accepted.
- Single command, angle 0, then drive `frame_tick` every 100 cycles. Required response:
  - `cmd_ready` is low for exactly 2 cycles after acceptance.
  - `pulse_width` goes 16930, 16430, … down to 6430, then 6000 at the 23rd tick.
  - `at_target` rises one cycle after the final tick.
- Clamp: angle 200 → `cmd_err` high for 1 cycle. `target` = 6000 + 180×127 = 28860, clamped to 28800.
- Handshake protocol: hold `cmd_valid` high with angle 45 then 90 back-to-back. Required response:
  - The second command is accepted 3 cycles after the first.
  - Final `target` = 17430.
- Simultaneous events: LOAD coincides with `frame_tick`. Required response: that tick slews toward the old target, and the next tick slews toward the new one.
- Small move: from 17430 command angle 91 (target 17557). One `frame_tick` → `pulse_width` = 17557 (diff 127 ≤ `STEP`).
